// File: rtl/raycast_column_buffer_if.sv
// Bus between the raycast datapath / VGA pixel generator and the column buffer.
interface raycast_column_buffer_if;
  logic        col_valid;
  logic [12:0] col_ceil;
  logic        col_hit;
  logic        col_ready;
  logic        frame_start;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic [1:0]  pixel_class;
  logic        frame_done;
  logic [7:0]  drop_count;

  modport master (
    output col_valid, col_ceil, col_hit, frame_start, DrawX, DrawY,
    input  col_ready, pixel_class, frame_done, drop_count
  );

  modport slave (
    input  col_valid, col_ceil, col_hit, frame_start, DrawX, DrawY,
    output col_ready, pixel_class, frame_done, drop_count
  );
endinterface

// File: rtl/raycast_column_buffer.sv
// Double-buffered per-column ceiling/hit store; the raycaster fills one bank while
// the VGA side classifies pixels from the other, banks swapping at frame_start.
module raycast_column_buffer #(
  parameter int unsigned NUM_COLS = 640,
  parameter int unsigned SCREEN_H = 480
) (
  input  logic                    Clk,
  input  logic                    Reset,
  raycast_column_buffer_if.slave  bus
);

  localparam int unsigned COL_W  = 10;
  localparam int unsigned CEIL_W = 13;
  localparam int unsigned H_W    = 8;
  localparam int unsigned CNT_W  = 8;

  localparam logic [COL_W-1:0]  LAST_COL = COL_W'(NUM_COLS - 1);
  localparam logic [COL_W-1:0]  COLS_W   = COL_W'(NUM_COLS);
  localparam logic [COL_W-1:0]  ROWS_W   = COL_W'(SCREEN_H);
  localparam logic [CEIL_W-1:0] HALF_C   = CEIL_W'(SCREEN_H / 2);
  localparam logic [H_W-1:0]    HALF_H   = H_W'(SCREEN_H / 2);

  typedef struct packed {
    logic           hit;
    logic [H_W-1:0] height;
  } entry_t;

  typedef enum logic {S_FILL, S_FULL} state_t;

  state_t             state, state_n;
  logic               wbank, wbank_n;
  logic [COL_W-1:0]   wr_col, wr_col_n;
  logic               frame_valid, frame_valid_n;
  logic [CNT_W-1:0]   drop_count_q, drop_n;
  logic               frame_done_q, done_n;
  logic               col_ready_q;
  logic [1:0]         pixel_class_q, class_n;
  logic               we;

  entry_t             mem [2][NUM_COLS];
  entry_t             wr_entry;
  entry_t             rd_entry;
  logic [COL_W-1:0]   rd_x;
  logic [COL_W-1:0]   rd_h;

  // Control: fill the write bank, then wait in FULL for the next frame_start to swap.
  always_comb begin
    state_n       = state;
    wbank_n       = wbank;
    wr_col_n      = wr_col;
    frame_valid_n = frame_valid;
    drop_n        = drop_count_q;
    done_n        = 1'b0;
    we            = 1'b0;
    case (state)
      S_FILL: begin
        if (bus.frame_start && (drop_count_q != '1))
          drop_n = drop_count_q + CNT_W'(1);
        if (bus.col_valid) begin
          we = 1'b1;
          if (wr_col == LAST_COL) begin
            state_n = S_FULL;
            done_n  = 1'b1;
          end else begin
            wr_col_n = wr_col + COL_W'(1);
          end
        end
      end
      S_FULL: begin
        if (bus.frame_start) begin
          wbank_n       = ~wbank;
          wr_col_n      = '0;
          frame_valid_n = 1'b1;
          state_n       = S_FILL;
        end
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state        <= S_FILL;
      wbank        <= 1'b0;
      wr_col       <= '0;
      frame_valid  <= 1'b0;
      drop_count_q <= '0;
      frame_done_q <= 1'b0;
      col_ready_q  <= 1'b1;
      pixel_class_q <= 2'b11;
    end else begin
      state        <= state_n;
      wbank        <= wbank_n;
      wr_col       <= wr_col_n;
      frame_valid  <= frame_valid_n;
      drop_count_q <= drop_n;
      frame_done_q <= done_n;
      col_ready_q  <= (state_n == S_FILL);
      pixel_class_q <= class_n;
    end
  end

  // Heights above half the screen would make ceiling and floor overlap, so clamp.
  always_comb begin
    wr_entry.hit    = bus.col_hit;
    wr_entry.height = (bus.col_ceil > HALF_C) ? HALF_H : bus.col_ceil[H_W-1:0];
  end

  always_ff @(posedge Clk) begin
    if (we)
      mem[wbank][wr_col] <= wr_entry;
  end

  // Pixel classification from the read bank (the one not being written).
  always_comb begin
    rd_x     = (bus.DrawX < COLS_W) ? bus.DrawX : '0;
    rd_entry = mem[~wbank][rd_x];
    rd_h     = COL_W'(rd_entry.height);
    class_n  = 2'b11;
    if (!frame_valid || (bus.DrawX >= COLS_W) || (bus.DrawY >= ROWS_W))
      class_n = 2'b11;
    else if (bus.DrawY < rd_h)
      class_n = 2'b00;
    else if (bus.DrawY >= (ROWS_W - rd_h))
      class_n = 2'b10;
    else if (rd_entry.hit)
      class_n = 2'b01;
    else
      class_n = 2'b11;
  end

  assign bus.col_ready   = col_ready_q;
  assign bus.pixel_class = pixel_class_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.drop_count  = drop_count_q;

endmodule

// File: tb/tb_raycast_column_buffer.sv
// Directed + randomized bench for raycast_column_buffer against a frame-level reference model.
module tb_raycast_column_buffer;

  localparam int NC = 640;
  localparam int SH = 480;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  raycast_column_buffer_if bus ();

  raycast_column_buffer #(.NUM_COLS(NC), .SCREEN_H(SH)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: pending frame being written and the frame on display.
  int m_wr_h  [NC];
  bit m_wr_hit[NC];
  int m_rd_h  [NC];
  bit m_rd_hit[NC];
  int m_ptr;
  bit m_full;
  bit m_fvalid;
  int m_drops;
  logic [1:0] exp_pc;
  logic       exp_done;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] ref_class(input int x, input int y);
    int h;
    if (!m_fvalid || x >= NC || y >= SH) return 2'b11;
    h = m_rd_h[x];
    if (y < h) return 2'b00;
    if (y >= SH - h) return 2'b10;
    return m_rd_hit[x] ? 2'b01 : 2'b11;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_full = 0; m_fvalid = 0; m_drops = 0;
    exp_pc = 2'b11; exp_done = 1'b0;
  endtask

  // One clock: update the model from the inputs presented at this edge, then check.
  task automatic cycle();
    int c;
    @(posedge Clk);
    if (Reset) begin
      exp_pc = 2'b11;
      exp_done = 1'b0;
    end else begin
      exp_pc = ref_class(int'(bus.DrawX), int'(bus.DrawY));
      exp_done = 1'b0;
      if (!m_full) begin
        if (bus.frame_start && m_drops < 255) m_drops++;
        if (bus.col_valid) begin
          c = int'(bus.col_ceil);
          m_wr_h[m_ptr]   = (c > SH / 2) ? SH / 2 : c;
          m_wr_hit[m_ptr] = bus.col_hit;
          if (m_ptr == NC - 1) begin
            m_full = 1;
            exp_done = 1'b1;
          end else begin
            m_ptr++;
          end
        end
      end else if (bus.frame_start) begin
        for (int i = 0; i < NC; i++) begin
          m_rd_h[i]   = m_wr_h[i];
          m_rd_hit[i] = m_wr_hit[i];
        end
        m_ptr = 0; m_full = 0; m_fvalid = 1;
      end
    end
    #1;
    chk("pixel_class", 8'(bus.pixel_class), 8'(exp_pc));
    chk("col_ready",   8'(bus.col_ready),   8'(!m_full));
    chk("frame_done",  8'(bus.frame_done),  8'(exp_done));
    chk("drop_count",  bus.drop_count,      8'(m_drops));
  endtask

  task automatic drive(input logic v, input int ceil, input logic hit, input logic fs);
    bus.col_valid   = v;
    bus.col_ceil    = 13'(ceil);
    bus.col_hit     = hit;
    bus.frame_start = fs;
    bus.DrawX       = 10'($urandom_range(0, 659));
    bus.DrawY       = 10'($urandom_range(0, 499));
  endtask

  task automatic idle(input int x, input int y, input logic fs);
    bus.col_valid   = 1'b0;
    bus.col_ceil    = '0;
    bus.col_hit     = 1'b0;
    bus.frame_start = fs;
    bus.DrawX       = 10'(x);
    bus.DrawY       = 10'(y);
  endtask

  // mode 0: 100/hit, mode 1: random with columns 3 and 7 pinned, mode 2: 60/hit
  task automatic fill(input int n, input int mode);
    int c;
    logic h;
    for (int i = 0; i < n; i++) begin
      case (mode)
        0: begin c = 100; h = 1'b1; end
        2: begin c = 60;  h = 1'b1; end
        default: begin
          c = $urandom_range(1, 400);
          h = 1'($urandom_range(0, 1));
          if (m_ptr == 3) begin c = 300; h = 1'b1; end
          if (m_ptr == 7) begin c = 50;  h = 1'b0; end
        end
      endcase
      drive(1'b1, c, h, 1'b0);
      cycle();
    end
  endtask

  task automatic rd(input string tag, input int x, input int y, input logic [1:0] expc);
    idle(x, y, 1'b0);
    cycle();
    chk(tag, 8'(bus.pixel_class), 8'(expc));
  endtask

  task automatic random_reads(input int n);
    for (int i = 0; i < n; i++) begin
      idle($urandom_range(0, 659), $urandom_range(0, 499), 1'b0);
      cycle();
    end
  endtask

  initial begin
    model_reset();
    Reset = 1'b1;
    idle(5, 5, 1'b0);
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_ready", 8'(bus.col_ready), 8'd1);
    chk("rst_class", 8'(bus.pixel_class), 8'd3);
    chk("rst_done",  8'(bus.frame_done), 8'd0);
    chk("rst_drops", bus.drop_count, 8'd0);
    Reset = 1'b0;
    rd("blank_5_5", 5, 5, 2'b11);

    // First frame: uniform height 100, all hits
    fill(NC, 0);
    chk("last_done",  8'(bus.frame_done), 8'd1);
    chk("last_ready", 8'(bus.col_ready), 8'd0);
    drive(1'b1, 200, 1'b0, 1'b0);   // protocol-error write while full: dropped
    cycle();
    idle(0, 0, 1'b1);
    cycle();
    rd("f1_10_50",  10, 50,  2'b00);
    rd("f1_10_100", 10, 100, 2'b01);
    rd("f1_10_379", 10, 379, 2'b01);
    rd("f1_10_380", 10, 380, 2'b10);

    // Early frame_start mid-fill: no swap, drop counted
    fill(320, 1);
    idle(0, 0, 1'b1);
    cycle();
    chk("early_drops", bus.drop_count, 8'd1);
    rd("old_frame", 10, 50, 2'b00);
    fill(320, 1);
    idle(0, 0, 1'b1);
    cycle();
    rd("clamp_3_239", 3, 239, 2'b00);
    rd("clamp_3_240", 3, 240, 2'b10);
    rd("nohit_7_200", 7, 200, 2'b11);
    rd("xoob", 640, 10, 2'b11);
    rd("yoob", 10, 480, 2'b11);
    random_reads(300);

    // Last column coincident with frame_start
    fill(NC - 1, 1);
    drive(1'b1, 77, 1'b1, 1'b1);
    cycle();
    chk("coinc_ready", 8'(bus.col_ready), 8'd0);
    chk("coinc_drops", bus.drop_count, 8'd2);
    idle(0, 0, 1'b1);
    cycle();
    rd("last_639_76", 639, 76, 2'b00);
    rd("last_639_77", 639, 77, 2'b01);

    // Drop counter saturation
    for (int i = 0; i < 300; i++) begin
      drive(1'b0, 0, 1'b0, 1'b1);
      cycle();
    end
    chk("drops_sat", bus.drop_count, 8'd255);

    // Reset mid-fill, then a fresh frame
    fill(200, 1);
    idle(0, 0, 1'b0);
    Reset = 1'b1;
    #2;
    chk("mid_rst_ready", 8'(bus.col_ready), 8'd1);
    chk("mid_rst_class", 8'(bus.pixel_class), 8'd3);
    chk("mid_rst_done",  8'(bus.frame_done), 8'd0);
    chk("mid_rst_drops", bus.drop_count, 8'd0);
    model_reset();
    cycle();
    @(negedge Clk);
    Reset = 1'b0;
    rd("post_rst_blank", 10, 30, 2'b11);
    fill(NC, 2);
    idle(0, 0, 1'b1);
    cycle();
    rd("new_10_30",  10, 30,  2'b00);
    rd("new_10_100", 10, 100, 2'b01);
    rd("new_10_420", 10, 420, 2'b10);
    random_reads(200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
